// File: rtl/anita3_buffer_hold_scheduler_pkg.sv
// Shared constants, state encoding and helpers for the SURF buffer hold scheduler.
package anita3_buffer_hold_scheduler_pkg;

  localparam int unsigned NUM_BUFFERS = 4;
  localparam int unsigned BUF_W       = 2;
  localparam int unsigned SRC_W       = 4;

  localparam logic [BUF_W-1:0] BUF_A = 2'd0;
  localparam logic [BUF_W-1:0] BUF_B = 2'd1;
  localparam logic [BUF_W-1:0] BUF_C = 2'd2;
  localparam logic [BUF_W-1:0] BUF_D = 2'd3;

  typedef enum logic [1:0] {
    SCHED_IDLE     = 2'd0,
    SCHED_DIGITIZE = 2'd1,
    SCHED_HOLDOFF  = 2'd2
  } sched_state_e;

  // One-hot mask for a buffer index.
  function automatic logic [NUM_BUFFERS-1:0] buf_onehot(input logic [BUF_W-1:0] idx);
    logic [NUM_BUFFERS-1:0] m;
    m = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/anita3_buffer_hold_scheduler_if.sv
// Trigger-side / generator-side signal bundle of the scheduler.
interface anita3_buffer_hold_scheduler_if #(
  parameter int unsigned CNT_W = 16
);
  import anita3_buffer_hold_scheduler_pkg::*;

  logic                   enable_i;
  logic                   trigger_i;
  logic [SRC_W-1:0]       trigger_source_i;
  logic [NUM_BUFFERS-1:0] clear_i;
  logic                   count_clear_i;
  logic                   digitize_o;
  logic [BUF_W-1:0]       digitize_buffer_o;
  logic [SRC_W-1:0]       digitize_source_o;
  logic [NUM_BUFFERS-1:0] buffer_status_o;
  logic                   dead_o;
  logic [CNT_W-1:0]       dropped_count_o;
  logic [CNT_W-1:0]       deadtime_count_o;

  // Trigger logic / readout side.
  modport master (
    output enable_i, trigger_i, trigger_source_i, clear_i, count_clear_i,
    input  digitize_o, digitize_buffer_o, digitize_source_o, buffer_status_o,
           dead_o, dropped_count_o, deadtime_count_o
  );

  // Scheduler side.
  modport slave (
    input  enable_i, trigger_i, trigger_source_i, clear_i, count_clear_i,
    output digitize_o, digitize_buffer_o, digitize_source_o, buffer_status_o,
           dead_o, dropped_count_o, deadtime_count_o
  );
endinterface

// File: rtl/anita3_rr_free_picker.sv
// Combinational round-robin search for the first free buffer starting at a pointer.
module anita3_rr_free_picker
  import anita3_buffer_hold_scheduler_pkg::*;
(
  input  logic [NUM_BUFFERS-1:0] busy_i,
  input  logic [BUF_W-1:0]       start_i,
  output logic                   found_c,
  output logic [BUF_W-1:0]       idx_c
);

  logic [BUF_W-1:0] cand;

  // Scan from the farthest offset down so the nearest free buffer wins.
  always_comb begin
    found_c = 1'b0;
    idx_c   = start_i;
    cand    = start_i;
    for (int i = NUM_BUFFERS - 1; i >= 0; i--) begin
      cand = start_i + BUF_W'(i);
      if (!busy_i[cand]) begin
        found_c = 1'b1;
        idx_c   = cand;
      end
    end
  end

endmodule

// File: rtl/anita3_buffer_hold_scheduler.sv
// Digitize scheduler: accepts triggers, allocates a held buffer round-robin,
// paces the event generator and keeps dead/drop accounting.
module anita3_buffer_hold_scheduler
  import anita3_buffer_hold_scheduler_pkg::*;
#(
  parameter int unsigned DIG_LEN = 4,
  parameter int unsigned HOLDOFF = 8,
  parameter int unsigned CNT_W   = 16
) (
  input  logic clk125_i,
  input  logic rst_n_i,
  anita3_buffer_hold_scheduler_if.slave bus
);

  localparam int unsigned TMR_MAX = (DIG_LEN > HOLDOFF) ? DIG_LEN : HOLDOFF;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  // Async-assert, sync-release reset.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk125_i or negedge rst_n_i) begin
    if (!rst_n_i) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  sched_state_e           state_q, state_d;
  logic [TMR_W-1:0]       tmr_q, tmr_d;
  logic [BUF_W-1:0]       ptr_q, ptr_d;
  logic                   digitize_q, digitize_d;
  logic [BUF_W-1:0]       dbuf_q, dbuf_d;
  logic [SRC_W-1:0]       dsrc_q, dsrc_d;
  logic [NUM_BUFFERS-1:0] status_q, status_d;
  logic                   dead_q, dead_d;
  logic [CNT_W-1:0]       dropped_q, dropped_d;
  logic [CNT_W-1:0]       deadtime_q, deadtime_d;

  logic                   pick_found;
  logic [BUF_W-1:0]       pick_idx;
  logic                   trig_en;
  logic                   accept;
  logic [NUM_BUFFERS-1:0] alloc_mask;

  // Acceptance decision uses pre-clear status.
  anita3_rr_free_picker u_picker (
    .busy_i  (status_q),
    .start_i (ptr_q),
    .found_c (pick_found),
    .idx_c   (pick_idx)
  );

  // Next-state: FSM, shared timer, allocation, status and counters.
  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    ptr_d      = ptr_q;
    digitize_d = digitize_q;
    dbuf_d     = dbuf_q;
    dsrc_d     = dsrc_q;
    alloc_mask = '0;
    accept     = 1'b0;
    trig_en    = bus.trigger_i && bus.enable_i;

    case (state_q)
      SCHED_IDLE: begin
        if (trig_en && pick_found) begin
          accept     = 1'b1;
          state_d    = SCHED_DIGITIZE;
          tmr_d      = TMR_W'(DIG_LEN - 1);
          digitize_d = 1'b1;
          dbuf_d     = pick_idx;
          dsrc_d     = bus.trigger_source_i;
          ptr_d      = pick_idx + BUF_W'(1);
          alloc_mask = buf_onehot(pick_idx);
        end
      end
      SCHED_DIGITIZE: begin
        if (tmr_q == '0) begin
          state_d    = SCHED_HOLDOFF;
          digitize_d = 1'b0;
          tmr_d      = TMR_W'(HOLDOFF - 1);
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      SCHED_HOLDOFF: begin
        if (tmr_q == '0) state_d = SCHED_IDLE;
        else             tmr_d   = tmr_q - TMR_W'(1);
      end
      default: begin
        state_d    = SCHED_IDLE;
        digitize_d = 1'b0;
      end
    endcase

    // Allocation overrides a same-edge clear of the same buffer.
    status_d = (status_q & ~bus.clear_i) | alloc_mask;
    dead_d   = (state_d != SCHED_IDLE) || (&status_d);

    dropped_d = dropped_q;
    if (bus.count_clear_i)                          dropped_d = '0;
    else if (trig_en && !accept && dropped_q != '1) dropped_d = dropped_q + CNT_W'(1);

    deadtime_d = deadtime_q;
    if (bus.count_clear_i)                                 deadtime_d = '0;
    else if (dead_q && bus.enable_i && deadtime_q != '1)   deadtime_d = deadtime_q + CNT_W'(1);
  end

  // State and output registers.
  always_ff @(posedge clk125_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SCHED_IDLE;
      tmr_q      <= '0;
      ptr_q      <= BUF_A;
      digitize_q <= 1'b0;
      dbuf_q     <= '0;
      dsrc_q     <= '0;
      status_q   <= '0;
      dead_q     <= 1'b0;
      dropped_q  <= '0;
      deadtime_q <= '0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      ptr_q      <= ptr_d;
      digitize_q <= digitize_d;
      dbuf_q     <= dbuf_d;
      dsrc_q     <= dsrc_d;
      status_q   <= status_d;
      dead_q     <= dead_d;
      dropped_q  <= dropped_d;
      deadtime_q <= deadtime_d;
    end
  end

  assign bus.digitize_o        = digitize_q;
  assign bus.digitize_buffer_o = dbuf_q;
  assign bus.digitize_source_o = dsrc_q;
  assign bus.buffer_status_o   = status_q;
  assign bus.dead_o            = dead_q;
  assign bus.dropped_count_o   = dropped_q;
  assign bus.deadtime_count_o  = deadtime_q;

endmodule

// File: tb/tb_anita3_buffer_hold_scheduler.sv
// Directed bench for the buffer hold scheduler (DIG_LEN=4, HOLDOFF=8, CNT_W=16).
module tb_anita3_buffer_hold_scheduler;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   dig_cnt;
  int   dead_cnt;

  anita3_buffer_hold_scheduler_if #(.CNT_W(16)) bus ();

  anita3_buffer_hold_scheduler #(
    .DIG_LEN (4),
    .HOLDOFF (8),
    .CNT_W   (16)
  ) dut (
    .clk125_i (clk),
    .rst_n_i  (rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #4 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One-cycle trigger; returns at the negedge just after the sampling edge.
  task automatic pulse_trigger(input logic [3:0] src);
    @(negedge clk);
    bus.trigger_i        = 1'b1;
    bus.trigger_source_i = src;
    @(negedge clk);
    bus.trigger_i = 1'b0;
  endtask

  // Accepted trigger expected; waits until the scheduler is idle again.
  task automatic alloc(input string tag, input logic [3:0] src, input logic [1:0] exp_buf);
    pulse_trigger(src);
    check({tag, "_dig"}, 32'(bus.digitize_o), 32'd1);
    check({tag, "_buf"}, 32'(bus.digitize_buffer_o), 32'(exp_buf));
    check({tag, "_src"}, 32'(bus.digitize_source_o), 32'(src));
    repeat (15) @(negedge clk);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus.enable_i         = 1'b1;
    bus.trigger_i        = 1'b0;
    bus.trigger_source_i = 4'h0;
    bus.clear_i          = 4'h0;
    bus.count_clear_i    = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_dig",    32'(bus.digitize_o), 32'd0);
    check("rst_status", 32'(bus.buffer_status_o), 32'd0);
    check("rst_dead",   32'(bus.dead_o), 32'd0);
    check("rst_drop",   32'(bus.dropped_count_o), 32'd0);
    check("rst_dtime",  32'(bus.deadtime_count_o), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // First trigger: 4 digitize cycles, 12 dead cycles
    pulse_trigger(4'h5);
    check("t1_buf",    32'(bus.digitize_buffer_o), 32'd0);
    check("t1_src",    32'(bus.digitize_source_o), 32'h5);
    check("t1_status", 32'(bus.buffer_status_o), 32'h1);
    dig_cnt  = 0;
    dead_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (bus.digitize_o) dig_cnt++;
      if (bus.dead_o)     dead_cnt++;
      @(negedge clk);
    end
    check("t1_dig_len",  32'(dig_cnt), 32'd4);
    check("t1_dead_len", 32'(dead_cnt), 32'd12);
    check("t1_dtime",    32'(bus.deadtime_count_o), 32'd12);
    check("t1_drop",     32'(bus.dropped_count_o), 32'd0);

    // Fill remaining buffers round-robin, then a fifth trigger drops
    alloc("a1", 4'h1, 2'd1);
    alloc("a2", 4'h2, 2'd2);
    alloc("a3", 4'h3, 2'd3);
    check("full_status", 32'(bus.buffer_status_o), 32'hF);
    check("full_dead",   32'(bus.dead_o), 32'd1);
    pulse_trigger(4'h6);
    check("t5_dig",  32'(bus.digitize_o), 32'd0);
    check("t5_drop", 32'(bus.dropped_count_o), 32'd1);

    // Clear of C with simultaneous trigger: dropped; next cycle allocates C
    @(negedge clk);
    bus.clear_i          = 4'b0100;
    bus.trigger_i        = 1'b1;
    bus.trigger_source_i = 4'h7;
    @(negedge clk);
    bus.clear_i = 4'h0;
    check("clr_drop",   32'(bus.dropped_count_o), 32'd2);
    check("clr_status", 32'(bus.buffer_status_o), 32'hB);
    check("clr_dig",    32'(bus.digitize_o), 32'd0);
    @(negedge clk);
    bus.trigger_i = 1'b0;
    check("clr_next_dig",    32'(bus.digitize_o), 32'd1);
    check("clr_next_buf",    32'(bus.digitize_buffer_o), 32'd2);
    check("clr_next_status", 32'(bus.buffer_status_o), 32'hF);
    repeat (15) @(negedge clk);

    // next_ptr=3, status=1001: wrap skips D and A, picks B
    bus.clear_i = 4'b0110;
    @(negedge clk);
    bus.clear_i = 4'h0;
    check("wrap_pre_status", 32'(bus.buffer_status_o), 32'h9);
    alloc("wrap", 4'hA, 2'd1);
    check("wrap_status", 32'(bus.buffer_status_o), 32'hB);
    bus.clear_i = 4'hF;
    @(negedge clk);
    bus.clear_i = 4'h0;
    check("clrall_status", 32'(bus.buffer_status_o), 32'h0);

    // Pointer now 2; trigger during HOLDOFF is dropped, sequence unchanged
    pulse_trigger(4'h9);
    check("ho_buf", 32'(bus.digitize_buffer_o), 32'd2);
    repeat (6) @(negedge clk);
    bus.trigger_i = 1'b1;
    @(negedge clk);
    bus.trigger_i = 1'b0;
    check("ho_drop", 32'(bus.dropped_count_o), 32'd3);
    check("ho_dig",  32'(bus.digitize_o), 32'd0);
    check("ho_src",  32'(bus.digitize_source_o), 32'h9);
    repeat (4) @(negedge clk);
    check("ho_dead_11", 32'(bus.dead_o), 32'd1);
    @(negedge clk);
    check("ho_dead_12", 32'(bus.dead_o), 32'd0);
    check("ho_status",  32'(bus.buffer_status_o), 32'h4);

    // Counter clear, then enable dropped mid-DIGITIZE: no counting, no abort
    @(negedge clk);
    bus.count_clear_i = 1'b1;
    @(negedge clk);
    bus.count_clear_i = 1'b0;
    check("cc_drop",  32'(bus.dropped_count_o), 32'd0);
    check("cc_dtime", 32'(bus.deadtime_count_o), 32'd0);
    pulse_trigger(4'hC);
    check("en_buf", 32'(bus.digitize_buffer_o), 32'd3);
    bus.enable_i = 1'b0;
    dig_cnt = 0;
    for (int i = 1; i <= 13; i++) begin
      @(negedge clk);
      bus.trigger_i = (i == 1);
      if (bus.digitize_o) dig_cnt++;
    end
    bus.trigger_i = 1'b0;
    check("en_dig_len", 32'(dig_cnt), 32'd3);
    check("en_dtime",   32'(bus.deadtime_count_o), 32'd0);
    check("en_drop",    32'(bus.dropped_count_o), 32'd0);
    pulse_trigger(4'hD);
    check("dis_dig",    32'(bus.digitize_o), 32'd0);
    check("dis_drop",   32'(bus.dropped_count_o), 32'd0);
    check("dis_status", 32'(bus.buffer_status_o), 32'hC);
    bus.enable_i = 1'b1;

    // Saturation of both counters, then clear wins over a drop
    alloc("s0", 4'h1, 2'd0);
    alloc("s1", 4'h2, 2'd1);
    check("sat_status", 32'(bus.buffer_status_o), 32'hF);
    bus.trigger_i = 1'b1;
    repeat (65540) @(negedge clk);
    check("sat_drop",  32'(bus.dropped_count_o), 32'hFFFF);
    check("sat_dtime", 32'(bus.deadtime_count_o), 32'hFFFF);
    bus.count_clear_i = 1'b1;
    @(negedge clk);
    bus.count_clear_i = 1'b0;
    check("ccp_drop",  32'(bus.dropped_count_o), 32'd0);
    check("ccp_dtime", 32'(bus.deadtime_count_o), 32'd0);
    @(negedge clk);
    bus.trigger_i = 1'b0;
    check("ccp_drop1",  32'(bus.dropped_count_o), 32'd1);
    check("ccp_dtime1", 32'(bus.deadtime_count_o), 32'd1);

    // Reset mid-DIGITIZE clears outputs asynchronously
    bus.clear_i = 4'hF;
    @(negedge clk);
    bus.clear_i = 4'h0;
    pulse_trigger(4'hE);
    check("mr_buf", 32'(bus.digitize_buffer_o), 32'd2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mr_dig",    32'(bus.digitize_o), 32'd0);
    check("mr_status", 32'(bus.buffer_status_o), 32'd0);
    check("mr_dead",   32'(bus.dead_o), 32'd0);
    check("mr_drop",   32'(bus.dropped_count_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    alloc("post_rst", 4'h3, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
